// File: rtl/jamma_input_mux.sv
// Time-multiplexed JAMMA joystick sampler with per-player debounce and coin conditioning.
// Define JAMMA_COIN_STRETCH_EN to stretch short coin pulses to a minimum low width.
//
//   state  | meaning
//   SETTLE | wait for the adapter to settle after a select change
//   SAMPLE | compare bus against last sample, debounce, update player output
//   NEXT   | advance select, pulse frame_done after the last player
module jamma_input_mux #(
  parameter int NUM_PLAYERS  = 2,
  parameter int JOY_W        = 8,
  parameter int SEL_W        = 2,
  parameter int SETTLE_CYC   = 4,
  parameter int DEBOUNCE_N   = 3,
  parameter int COIN_STRETCH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic [JOY_W-1:0]             jjoy_in,
  input  logic [1:0]                   jcoin_in,
  output logic [SEL_W-1:0]             jselect,
  output logic [NUM_PLAYERS*JOY_W-1:0] joy_out,
  output logic [1:0]                   coin_out,
  output logic                         frame_done
);

  typedef enum logic [1:0] {ST_SETTLE, ST_SAMPLE, ST_NEXT} state_t;

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_PLAYERS - 1);
  localparam logic [3:0]       DB_MAX      = 4'(DEBOUNCE_N - 1);

  logic [JOY_W-1:0] joy_s1, joy_s2;
  logic [1:0]       coin_s1, coin_s2;

  state_t           state, state_nxt;
  logic [7:0]       settle_cnt, settle_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             frame_nxt;
  logic             sample_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy_s1  <= '1;
      joy_s2  <= '1;
      coin_s1 <= '1;
      coin_s2 <= '1;
    end else begin
      joy_s1  <= jjoy_in;
      joy_s2  <= joy_s1;
      coin_s1 <= jcoin_in;
      coin_s2 <= coin_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SETTLE;
      settle_cnt <= SETTLE_LOAD;
      jselect    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      jselect    <= sel_nxt;
      frame_done <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    sel_nxt    = jselect;
    frame_nxt  = 1'b0;
    sample_en  = 1'b0;
    if (ce) begin
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == '0) state_nxt = ST_SAMPLE;
          else                  settle_nxt = settle_cnt - 8'd1;
        end
        ST_SAMPLE: begin
          sample_en = 1'b1;
          state_nxt = ST_NEXT;
        end
        ST_NEXT: begin
          if (jselect == LAST_SEL) begin
            sel_nxt   = '0;
            frame_nxt = 1'b1;
          end else begin
            sel_nxt = jselect + SEL_W'(1);
          end
          settle_nxt = SETTLE_LOAD;
          state_nxt  = ST_SETTLE;
        end
        default: state_nxt = ST_SETTLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    logic [JOY_W-1:0] last_q;
    logic [JOY_W-1:0] joy_q;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_inc;
    logic             hit;
    logic             same;

    assign hit     = sample_en && (jselect == SEL_W'(p));
    assign same    = (joy_s2 == last_q);
    assign cnt_inc = (cnt_q == DB_MAX) ? cnt_q : cnt_q + 4'd1;

    // A differing sample restarts the run; with a single-sample debounce it is taken at once.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        last_q <= '1;
        joy_q  <= '1;
        cnt_q  <= '0;
      end else if (hit) begin
        if (same) begin
          cnt_q <= cnt_inc;
          if (cnt_inc == DB_MAX) joy_q <= joy_s2;
        end else begin
          last_q <= joy_s2;
          cnt_q  <= '0;
          if (DEBOUNCE_N == 1) joy_q <= joy_s2;
        end
      end
    end

    assign joy_out[p*JOY_W +: JOY_W] = joy_q;
  end

`ifdef JAMMA_COIN_STRETCH_EN
  localparam logic [7:0] COIN_LOAD = 8'(COIN_STRETCH - 1);

  for (genvar i = 0; i < 2; i++) begin : g_coin
    logic [7:0] ccnt;
    logic       busy;

    // Edge seen one stage early so the stretch starts on the same clk the synced input falls.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ccnt <= '0;
        busy <= 1'b0;
      end else if (!coin_s1[i] && coin_s2[i]) begin
        ccnt <= COIN_LOAD;
        busy <= 1'b1;
      end else if (ce && busy) begin
        if (ccnt != '0)    ccnt <= ccnt - 8'd1;
        else if (coin_s2[i]) busy <= 1'b0;
      end
    end

    assign coin_out[i] = coin_s2[i] & ~busy;
  end
`else
  assign coin_out = coin_s2;
`endif

endmodule

// File: tb/tb_jamma_input_mux.sv
// Scoreboard bench for jamma_input_mux: default two-player instance plus a four-player instance.
module tb_jamma_input_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [7:0]  jjoy_in;
  logic [1:0]  jcoin_in;
  logic [1:0]  jselect;
  logic [15:0] joy_out;
  logic [1:0]  coin_out;
  logic        frame_done;

  logic        ce4 = 1'b1;
  logic [7:0]  jjoy4;
  logic [1:0]  jsel4;
  logic [31:0] joy4;
  logic [1:0]  coin4;
  logic        fd4;

  logic [7:0]  pat0, pat1;

  jamma_input_mux u_dut (
    .clk(clk), .reset(reset), .ce(ce), .jjoy_in(jjoy_in), .jcoin_in(jcoin_in),
    .jselect(jselect), .joy_out(joy_out), .coin_out(coin_out), .frame_done(frame_done)
  );

  jamma_input_mux #(.NUM_PLAYERS(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .reset(reset), .ce(ce4), .jjoy_in(jjoy4), .jcoin_in(2'b11),
    .jselect(jsel4), .joy_out(joy4), .coin_out(coin4), .frame_done(fd4)
  );

  always #5 clk = ~clk;

  // The JAMMA adapter: bus content follows the select lines.
  always_comb jjoy_in = (jselect == 2'd0) ? pat0 : pat1;
  always_comb jjoy4   = (jsel4 == 2'd2) ? 8'hA5 : 8'hFF;

`ifdef JAMMA_COIN_STRETCH_EN
  localparam int COIN_W = 16;
`else
  localparam int COIN_W = 1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] joy;
    int          period;
  } frame_exp_t;

  typedef struct {
    logic [7:0]  p0;
    logic [7:0]  p1;
    int          mode;   // 0: ce=1, 1: ce every other clk, 2: ce=0 for 20 clk then ce=1
    logic [15:0] joy;
    int          period;
  } vec_t;

  frame_exp_t fq[$];
  logic [1:0] sel_q[$];
  logic [31:0] f4_q[$];
  int coin_q0[$];
  int coin_q1[$];

  vec_t vecs[14];

  // Frame scoreboard for the two-player instance.
  int last_fd = 0;
  always @(negedge clk) begin
    if (reset) begin
      last_fd = cyc;
    end else if (frame_done) begin
      if (fq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_unexpected: got frame_done expected none (cyc %0d)", cyc);
      end else begin
        frame_exp_t e;
        e = fq.pop_front();
        chk("joy_out", 32'(joy_out), 32'(e.joy));
        chk("frame_period", 32'(cyc - last_fd), 32'(e.period));
        chk("jselect_wrap", 32'(jselect), 32'd0);
      end
      last_fd = cyc;
    end
  end

  // Select sequence and frame scoreboard for the four-player instance.
  logic [1:0] prev_sel4 = 2'd0;
  always @(negedge clk) begin
    if (reset) begin
      prev_sel4 = 2'd0;
    end else begin
      if (jsel4 != prev_sel4 && sel_q.size() > 0) chk("sel4_seq", 32'(jsel4), 32'(sel_q.pop_front()));
      if (fd4) begin
        chk("fd4_on_wrap", 32'({prev_sel4, jsel4}), 32'h3 << 2);
        if (f4_q.size() > 0) chk("joy4", joy4, f4_q.pop_front());
      end
      prev_sel4 = jsel4;
    end
  end

  // Coin pulse scoreboard: latency from input pulse and low width.
  logic [1:0] prev_coin = 2'b11;
  int coin_start[2];
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!coin_out[b] && prev_coin[b]) coin_start[b] = cyc;
      if (coin_out[b] && !prev_coin[b]) begin
        int pc;
        pc = -100;
        if (b == 0 && coin_q0.size() > 0) pc = coin_q0.pop_front();
        if (b == 1 && coin_q1.size() > 0) pc = coin_q1.pop_front();
        chk(b == 0 ? "coin0_latency" : "coin1_latency", 32'(coin_start[b] - pc), 32'd2);
        chk(b == 0 ? "coin0_width" : "coin1_width", 32'(cyc - coin_start[b]), 32'(COIN_W));
      end
    end
    prev_coin = coin_out;
  end

  task automatic wait_frame(input int mode);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      else if (mode == 1) ce = ~ce;
      else ce = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: got no frame_done expected one within 200 clk");
    end
  endtask

  initial begin
    vecs = '{
      '{8'hFE, 8'hFD, 0, 16'hFFFF, 12},
      '{8'hFE, 8'hFD, 0, 16'hFFFF, 12},
      '{8'hFE, 8'hFD, 0, 16'hFDFE, 12},
      '{8'hEF, 8'hFD, 0, 16'hFDFE, 12},
      '{8'hFF, 8'hFD, 0, 16'hFDFE, 12},
      '{8'hFF, 8'hFD, 0, 16'hFDFE, 12},
      '{8'hFF, 8'hFD, 0, 16'hFDFF, 12},
      '{8'hFF, 8'h7F, 0, 16'hFDFF, 12},
      '{8'hFF, 8'h7F, 0, 16'hFDFF, 12},
      '{8'hFF, 8'h7F, 0, 16'h7FFF, 12},
      '{8'hFB, 8'h7F, 1, 16'h7FFF, 24},
      '{8'hFB, 8'h7F, 1, 16'h7FFF, 24},
      '{8'hFB, 8'h7F, 1, 16'h7FFB, 24},
      '{8'hFB, 8'h7F, 2, 16'h7FFB, 32}
    };

    reset = 1'b1; ce = 1'b1; pat0 = 8'h00; pat1 = 8'h5A; jcoin_in = 2'b00;
    for (int i = 0; i < 12; i++) sel_q.push_back(2'((i + 1) % 4));
    f4_q.push_back(32'hFFFF_FFFF);
    f4_q.push_back(32'hFFFF_FFFF);
    f4_q.push_back(32'hFFA5_FFFF);
    f4_q.push_back(32'hFFA5_FFFF);

    repeat (3) begin
      @(negedge clk);
      chk("rst_joy_out", 32'(joy_out), 32'hFFFF);
      chk("rst_coin_out", 32'(coin_out), 32'h3);
      chk("rst_jselect", 32'(jselect), 32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      chk("rst_joy4", joy4, 32'hFFFF_FFFF);
    end
    jcoin_in = 2'b11;
    pat0 = vecs[0].p0;
    pat1 = vecs[0].p1;
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_joy_out", 32'(joy_out), 32'hFFFF);
    chk("post_rst_jselect", 32'(jselect), 32'h0);
    chk("post_rst_frame_done", 32'(frame_done), 32'h0);

    for (int i = 0; i < 14; i++) begin
      frame_exp_t e;
      pat0 = vecs[i].p0;
      pat1 = vecs[i].p1;
      e.joy = vecs[i].joy;
      e.period = vecs[i].period;
      fq.push_back(e);
      if (vecs[i].mode == 2) begin
        ce = 1'b0;
        repeat (20) begin
          @(negedge clk);
          chk("hold_jselect", 32'(jselect), 32'h0);
          chk("hold_joy_out", 32'(joy_out), 32'(vecs[i - 1].joy));
        end
        ce = 1'b1;
      end else if (vecs[i].mode == 1) begin
        ce = 1'b0;
      end else begin
        ce = 1'b1;
      end
      wait_frame(vecs[i].mode);
    end

    repeat (3) @(negedge clk);
    chk("frame_q_drained", 32'(fq.size()), 32'd0);
    chk("sel4_q_drained", 32'(sel_q.size()), 32'd0);
    chk("joy4_q_drained", 32'(f4_q.size()), 32'd0);
    chk("coin_q_drained", 32'(coin_q0.size() + coin_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Coin stimulus runs alongside the frame stimulus while ce is continuously high.
  initial begin
    wait (reset == 1'b0);
    repeat (3) @(negedge clk);
    jcoin_in[0] = 1'b0;
    coin_q0.push_back(cyc);
    @(negedge clk);
    jcoin_in[0] = 1'b1;
    repeat (30) @(negedge clk);
    jcoin_in[1] = 1'b0;
    coin_q1.push_back(cyc);
    @(negedge clk);
    jcoin_in[1] = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 20000 clk");
    $fatal(1, "watchdog expired");
  end

endmodule
